// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, queue entry layout and line sizing helpers
package fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DROP  = 3'd4,
        S_HALT  = 3'd5
    } fetch_state_e;

    localparam int DEFAULT_PC_WIDTH    = 32;
    localparam int DEFAULT_INSTR_WIDTH = 32;

    // Queue entry layout at the default widths; the top packs {pc, instr} in the same order.
    typedef struct packed {
        logic [DEFAULT_PC_WIDTH-1:0]    pc;
        logic [DEFAULT_INSTR_WIDTH-1:0] instr;
    } fetch_queue_entry_t;

    function automatic int calc_instr_per_line(input int line_width, input int instr_width);
        return line_width / instr_width;
    endfunction

    function automatic int calc_word_off_width(input int line_width, input int instr_width);
        return $clog2(line_width / instr_width);
    endfunction

endpackage

// File: rtl/fetch_instr_queue.sv
// rtl/fetch_instr_queue.sv - power-of-two FIFO holding unpacked instructions for decode
module fetch_instr_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    // a push into a full queue only lands when the head leaves in the same cycle
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < ($clog2(DEPTH)+1)'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    // pointer and occupancy tracking; flush wins over any same-cycle push or pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // entry storage; cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_line_prefetcher.sv
// rtl/fetch_line_prefetcher.sv - line-granular fetch FSM feeding a decoupled decode queue
module fetch_line_prefetcher
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [PC_WIDTH-1:0]            boot_addr,
    input  logic                           take_branch,
    input  logic [PC_WIDTH-1:0]            branch_pc,
    output logic                           decode_instr_valid,
    input  logic                           decode_instr_ready,
    output logic [INSTR_WIDTH-1:0]         decode_instr_data,
    output logic [PC_WIDTH-1:0]            decode_instr_pc,
    output logic                           icache_req_valid,
    input  logic                           icache_req_ready,
    output logic [PC_WIDTH-1:0]            icache_req_addr,
    input  logic                           icache_rsp_valid,
    input  logic [LINE_WIDTH-1:0]          icache_rsp_data,
    output logic                           xcpt_misaligned,
    output logic [PC_WIDTH-1:0]            xcpt_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
    localparam int INSTR_PER_LINE = calc_instr_per_line(LINE_WIDTH, INSTR_WIDTH);
    localparam int WORD_OFF_W     = calc_word_off_width(LINE_WIDTH, INSTR_WIDTH);
    localparam int LINE_OFF_W     = WORD_OFF_W + 2;
    localparam int COUNT_W        = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(INSTR_PER_LINE - 1);
    localparam logic [PC_WIDTH-1:0]   LINE_MASK = ~((PC_WIDTH'(1) << LINE_OFF_W) - PC_WIDTH'(1));

    fetch_state_e              state;
    logic [PC_WIDTH-1:0]       fetch_pc;
    logic [LINE_WIDTH-1:0]     line_buf;
    logic [WORD_OFF_W-1:0]     word_idx;
    logic [INSTR_WIDTH-1:0]    cur_word;
    logic [COUNT_W-1:0]        q_count;
    logic                      push;
    logic                      pop;
    logic                      flush;
    logic                      redirect;
    logic                      outstanding;

    assign redirect = take_branch && (state != S_BOOT);
    assign flush    = redirect;
    assign cur_word = line_buf[word_idx*INSTR_WIDTH +: INSTR_WIDTH];

    assign decode_instr_valid = (q_count != '0) && !take_branch;
    assign pop  = decode_instr_valid && decode_instr_ready;
    assign push = (state == S_DRAIN) && !take_branch &&
                  ((q_count < COUNT_W'(QUEUE_DEPTH)) || pop);

    // a response is still owed after this cycle: just accepted, or awaited and not arriving now
    assign outstanding = ((state == S_REQ) && icache_req_ready) ||
                         (((state == S_WAIT) || (state == S_DROP)) && !icache_rsp_valid);

    assign icache_req_valid = (state == S_REQ);
    assign icache_req_addr  = (state == S_REQ) ? (fetch_pc & LINE_MASK) : '0;
    assign xcpt_misaligned  = (state == S_HALT);
    assign xcpt_pc          = (state == S_HALT) ? fetch_pc : '0;
    assign queue_count      = q_count;

    // fetch sequencing: boot, line request, response capture, word-by-word drain, redirects
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_BOOT;
            fetch_pc <= '0;
            line_buf <= '0;
            word_idx <= '0;
        end else if (redirect) begin
            fetch_pc <= branch_pc;
            if (branch_pc[1:0] != 2'b00) state <= S_HALT;
            else if (outstanding)        state <= S_DROP;
            else                         state <= S_REQ;
        end else begin
            case (state)
                S_BOOT: begin
                    fetch_pc <= boot_addr;
                    state    <= (boot_addr[1:0] != 2'b00) ? S_HALT : S_REQ;
                end
                S_REQ: begin
                    if (icache_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (icache_rsp_valid) begin
                        line_buf <= icache_rsp_data;
                        word_idx <= fetch_pc[LINE_OFF_W-1:2];
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (push) begin
                        fetch_pc <= fetch_pc + PC_WIDTH'(4);
                        word_idx <= word_idx + 1'b1;
                        if (word_idx == LAST_WORD) state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (icache_rsp_valid) state <= S_REQ;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    fetch_instr_queue #(
        .DATA_WIDTH (PC_WIDTH + INSTR_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({fetch_pc, cur_word}),
        .pop       (pop),
        .flush     (flush),
        .head_data ({decode_instr_pc, decode_instr_data}),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_line_prefetcher.sv
// tb/tb_fetch_line_prefetcher.sv - randomized bench with cache model and stream reference
module tb_fetch_line_prefetcher;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  boot_addr;
    logic         take_branch;
    logic [31:0]  branch_pc;
    logic         decode_instr_valid;
    logic         decode_instr_ready;
    logic [31:0]  decode_instr_data;
    logic [31:0]  decode_instr_pc;
    logic         icache_req_valid;
    logic         icache_req_ready;
    logic [31:0]  icache_req_addr;
    logic         icache_rsp_valid;
    logic [127:0] icache_rsp_data;
    logic         xcpt_misaligned;
    logic [31:0]  xcpt_pc;
    logic [2:0]   queue_count;

    int checks = 0;
    int errors = 0;
    int cache_lat = 3;
    int cache_ready_pct = 100;
    int cyc = 0;

    logic [31:0] obs_req[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_data[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    always #5 clock = ~clock;

    fetch_line_prefetcher #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .LINE_WIDTH(128), .QUEUE_DEPTH(4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .boot_addr          (boot_addr),
        .take_branch        (take_branch),
        .branch_pc          (branch_pc),
        .decode_instr_valid (decode_instr_valid),
        .decode_instr_ready (decode_instr_ready),
        .decode_instr_data  (decode_instr_data),
        .decode_instr_pc    (decode_instr_pc),
        .icache_req_valid   (icache_req_valid),
        .icache_req_ready   (icache_req_ready),
        .icache_req_addr    (icache_req_addr),
        .icache_rsp_valid   (icache_rsp_valid),
        .icache_rsp_data    (icache_rsp_data),
        .xcpt_misaligned    (xcpt_misaligned),
        .xcpt_pc            (xcpt_pc),
        .queue_count        (queue_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word(base + 32'(4*i));
        return l;
    endfunction

    // decode pop monitor
    always @(negedge clock) begin
        if (reset && decode_instr_valid && decode_instr_ready) begin
            obs_pc.push_back(decode_instr_pc);
            obs_data.push_back(decode_instr_data);
        end
    end

    // cache model: in-order responses, one per accepted request, latency fixed at acceptance
    initial begin
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = '0;
    end

    always begin
        @(negedge clock);
        if (!reset) begin
            pend.delete();
        end else if (icache_req_valid && icache_req_ready) begin
            pend.push_back('{icache_req_addr, cyc + cache_lat});
            obs_req.push_back(icache_req_addr);
        end
        @(posedge clock);
        #1;
        cyc++;
        icache_rsp_valid = 1'b0;
        if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
            icache_rsp_valid = 1'b1;
            icache_rsp_data  = line_of(pend[0].addr);
            void'(pend.pop_front());
        end
        icache_req_ready = reset && ($urandom_range(99) < cache_ready_pct);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] target);
        branch_pc   = target;
        take_branch = 1'b1;
        step();
        take_branch = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        int c = 0;
        while (obs_pc.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (obs_pc.size() >= n);
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit ok);
        int c = 0;
        while (obs_req.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (obs_req.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        boot_addr = 32'h1000;
        take_branch = 1'b0;
        branch_pc = '0;
        decode_instr_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({icache_req_valid, decode_instr_valid, xcpt_misaligned} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids got req=%b dec=%b xcpt=%b want 0", icache_req_valid, decode_instr_valid, xcpt_misaligned);
        end
        checks++;
        if (queue_count !== 3'd0 || icache_req_addr !== 32'h0 || xcpt_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got count=%0d addr=%h xpc=%h want 0", queue_count, icache_req_addr, xcpt_pc);
        end
        checks++;
        if (decode_instr_pc !== 32'h0 || decode_instr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_head got pc=%h data=%h want 0", decode_instr_pc, decode_instr_data);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (icache_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req_cycle1 got %b want 0", icache_req_valid);
        end
        step();
        checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL first_req_cycle2 got valid=%b addr=%h want 1 00001000", icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_boot();
        bit ok;
        logic [31:0] exp;
        cache_lat = 3;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b1;
        wait_pops(4, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boot_pops timeout got %0d want 4", obs_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp = 32'h1000 + 32'(4*i);
                checks++;
                if (obs_pc[i] !== exp || obs_data[i] !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL boot_pop%0d got pc=%h data=%h want pc=%h data=%h", i, obs_pc[i], obs_data[i], exp, mem_word(exp));
                end
            end
        end
        wait_reqs(2, 100, ok);
        checks++;
        if (!ok || obs_req[0] !== 32'h1000 || obs_req[1] !== 32'h1010) begin
            errors++;
            $display("FAIL boot_reqs got n=%0d want 00001000 then 00001010", obs_req.size());
        end
        decode_instr_ready = 1'b0;
    endtask

    task automatic test_unaligned();
        bit ok;
        int sp, sr;
        logic [31:0] exp;
        cache_lat = 3;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b1;
        do_branch(32'h2008);
        sp = obs_pc.size();
        sr = obs_req.size();
        wait_pops(sp + 3, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL unaligned_pops timeout got %0d want 3", obs_pc.size() - sp);
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp = 32'h2008 + 32'(4*i);
                checks++;
                if (obs_pc[sp+i] !== exp || obs_data[sp+i] !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL unaligned_pop%0d got pc=%h data=%h want pc=%h", i, obs_pc[sp+i], obs_data[sp+i], exp);
                end
            end
        end
        wait_reqs(sr + 2, 100, ok);
        checks++;
        if (!ok || obs_req[sr] !== 32'h2000 || obs_req[sr+1] !== 32'h2010) begin
            errors++;
            $display("FAIL unaligned_reqs got n=%0d want 00002000 then 00002010", obs_req.size() - sr);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int sp, sr;
        logic [31:0] exp;
        cache_lat = 3;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b0;
        do_branch(32'h6000);
        sp = obs_pc.size();
        sr = obs_req.size();
        repeat (40) step();
        checks++;
        if (queue_count !== 3'd4 || obs_pc.size() != sp) begin
            errors++;
            $display("FAIL bp_saturate got count=%0d pops=%0d want 4 0", queue_count, obs_pc.size() - sp);
        end
        checks++;
        if (obs_req.size() != sr + 2 || obs_req[sr] !== 32'h6000 || obs_req[sr+1] !== 32'h6010) begin
            errors++;
            $display("FAIL bp_reqs got n=%0d want 00006000 then 00006010", obs_req.size() - sr);
        end
        decode_instr_ready = 1'b1;
        wait_pops(sp + 12, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_release timeout got %0d want 12", obs_pc.size() - sp);
        end else begin
            for (int i = 0; i < 12; i++) begin
                exp = 32'h6000 + 32'(4*i);
                checks++;
                if (obs_pc[sp+i] !== exp || obs_data[sp+i] !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL bp_pop%0d got pc=%h data=%h want pc=%h", i, obs_pc[sp+i], obs_data[sp+i], exp);
                end
            end
        end
    endtask

    task automatic test_branch_in_wait();
        bit ok;
        int sp, sr;
        logic [31:0] exp;
        cache_lat = 20;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b1;
        do_branch(32'h1000);
        sr = obs_req.size();
        wait_reqs(sr + 2, 200, ok);
        checks++;
        if (!ok || obs_req[sr+1] !== 32'h1010) begin
            errors++;
            $display("FAIL wait_setup got n=%0d want request 00001010", obs_req.size() - sr);
        end
        repeat (3) step();
        do_branch(32'h3000);
        cache_lat = 3;
        sp = obs_pc.size();
        sr = obs_req.size();
        wait_pops(sp + 4, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_pops timeout got %0d want 4", obs_pc.size() - sp);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp = 32'h3000 + 32'(4*i);
                checks++;
                if (obs_pc[sp+i] !== exp || obs_data[sp+i] !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL wait_pop%0d got pc=%h data=%h want pc=%h data=%h", i, obs_pc[sp+i], obs_data[sp+i], exp, mem_word(exp));
                end
            end
        end
        checks++;
        if (obs_req.size() <= sr || obs_req[sr] !== 32'h3000) begin
            errors++;
            $display("FAIL wait_req got n=%0d want 00003000", obs_req.size() - sr);
        end
        for (int i = sp; i < obs_pc.size(); i++) begin
            checks++;
            if (obs_pc[i][31:4] == 28'h0000_101) begin
                errors++;
                $display("FAIL wait_leak got pc=%h want no 0000101x", obs_pc[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        int sp, sr;
        cache_lat = 3;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b1;
        do_branch(32'h4002);
        sr = obs_req.size();
        checks++;
        if (xcpt_misaligned !== 1'b1 || xcpt_pc !== 32'h4002) begin
            errors++;
            $display("FAIL mis_xcpt got %b %h want 1 00004002", xcpt_misaligned, xcpt_pc);
        end
        checks++;
        if (queue_count !== 3'd0 || decode_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_flush got count=%0d valid=%b want 0 0", queue_count, decode_instr_valid);
        end
        repeat (30) step();
        checks++;
        if (obs_req.size() != sr || icache_req_valid !== 1'b0 || xcpt_misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_halt got reqs=%0d valid=%b xcpt=%b want 0 0 1", obs_req.size() - sr, icache_req_valid, xcpt_misaligned);
        end
        do_branch(32'h5000);
        sp = obs_pc.size();
        sr = obs_req.size();
        checks++;
        if (xcpt_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_leave got %b want 0", xcpt_misaligned);
        end
        wait_pops(sp + 4, 100, ok);
        checks++;
        if (!ok || obs_req[sr] !== 32'h5000 || obs_pc[sp] !== 32'h5000 || obs_pc[sp+3] !== 32'h500C) begin
            errors++;
            $display("FAIL mis_resume got pops=%0d reqs=%0d want fetch from 00005000", obs_pc.size() - sp, obs_req.size() - sr);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt[$];
        int ps[$];
        int rs[$];
        int cool = 0;
        int pe, re;
        logic [31:0] exp;
        for (int c = 0; c < 3000; c++) begin
            cache_lat = $urandom_range(1, 6);
            cache_ready_pct = 60;
            decode_instr_ready = ($urandom_range(9) < 7);
            if (cool == 0 && (c == 0 || $urandom_range(39) == 0)) begin
                do_branch($urandom & 32'hFFFF_FFFC);
                tgt.push_back(branch_pc);
                ps.push_back(obs_pc.size());
                rs.push_back(obs_req.size());
                cool = 2;
            end else begin
                step();
                if (cool > 0) cool--;
            end
        end
        for (int s = 0; s < tgt.size(); s++) begin
            pe = (s + 1 < tgt.size()) ? ps[s+1] : obs_pc.size();
            re = (s + 1 < tgt.size()) ? rs[s+1] : obs_req.size();
            for (int i = ps[s]; i < pe; i++) begin
                exp = tgt[s] + 32'(4*(i - ps[s]));
                checks++;
                if (obs_pc[i] !== exp || obs_data[i] !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL rand_pop seg%0d got pc=%h data=%h want pc=%h data=%h", s, obs_pc[i], obs_data[i], exp, mem_word(exp));
                end
            end
            for (int j = rs[s]; j < re; j++) begin
                exp = (tgt[s] & 32'hFFFF_FFF0) + 32'(16*(j - rs[s]));
                checks++;
                if (obs_req[j] !== exp) begin
                    errors++;
                    $display("FAIL rand_req seg%0d got %h want %h", s, obs_req[j], exp);
                end
            end
        end
        checks++;
        if (obs_pc.size() - ps[0] < 200) begin
            errors++;
            $display("FAIL rand_progress got %0d pops want at least 200", obs_pc.size() - ps[0]);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int c = 0;
        int sp, sr;
        cache_lat = 3;
        cache_ready_pct = 100;
        decode_instr_ready = 1'b0;
        do_branch(32'h7000);
        while (queue_count != 3'd2 && c < 50) begin
            step();
            c++;
        end
        checks++;
        if (queue_count !== 3'd2) begin
            errors++;
            $display("FAIL areset_setup got count=%0d want 2", queue_count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (queue_count !== 3'd0 || decode_instr_valid !== 1'b0 || icache_req_valid !== 1'b0 || icache_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_clear got count=%0d dec=%b req=%b addr=%h want 0", queue_count, decode_instr_valid, icache_req_valid, icache_req_addr);
        end
        checks++;
        if (xcpt_misaligned !== 1'b0 || xcpt_pc !== 32'h0 || decode_instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL areset_outs got xcpt=%b xpc=%h pc=%h want 0", xcpt_misaligned, xcpt_pc, decode_instr_pc);
        end
        boot_addr = 32'h8000;
        step();
        step();
        reset = 1'b1;
        sp = obs_pc.size();
        sr = obs_req.size();
        decode_instr_ready = 1'b1;
        wait_pops(sp + 4, 100, ok);
        checks++;
        if (!ok || obs_req[sr] !== 32'h8000 || obs_pc[sp] !== 32'h8000 || obs_data[sp+3] !== mem_word(32'h800C)) begin
            errors++;
            $display("FAIL areset_reboot got pops=%0d reqs=%0d want fetch from 00008000", obs_pc.size() - sp, obs_req.size() - sr);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_unaligned();
        test_backpressure();
        test_branch_in_wait();
        test_misaligned();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
